// File: rtl/regfile_pkg.sv
// Shared register-file types and constants used by the write-side front end.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of pending write-backs with an age-ordered view
// (view[0] is the head, the oldest entry) for the forwarding lookup.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  wb_entry_t                push_entry,
    output logic [$clog2(DEPTH):0]   count,
    output wb_entry_t                view [DEPTH],
    output logic                     view_valid [DEPTH]
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && (count < CW'(DEPTH));
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n && do_push) mem[tail] <= push_entry;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            view[k]       = mem[head + PW'(k)];
            view_valid[k] = CW'(k) < count;
        end
    end

endmodule

// File: rtl/regfile_write_sequencer.sv
// Buffers register write-backs and drains them into the register file write port.
// Optional macro WB_FWD_EN builds the forwarding lookup; otherwise lk_hit/lk_data are tied 0.
module regfile_write_sequencer
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_W-1:0]         in_dest,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      port_busy,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_dest,
    output logic [DATA_W-1:0]         wr_data,
    input  logic [ADDR_W-1:0]         lk_addr,
    output logic                      lk_hit,
    output logic [DATA_W-1:0]         lk_data,
    output logic [$clog2(DEPTH):0]    pending,
    output logic                      idle
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]  count;
    wb_entry_t      view [DEPTH];
    logic           view_valid [DEPTH];
    wb_entry_t      push_entry;
    logic           push;

    // Writes to r0 complete the handshake but never enter the queue.
    assign in_ready        = reset_n && (count < CW'(DEPTH));
    assign push            = in_valid && in_ready && (in_dest != ADDR_W'(REG_ZERO));
    assign push_entry.dest = REG_ADDR_W'(in_dest);
    assign push_entry.data = REG_DATA_W'(in_data);

    // The head pops on the same edge the register file samples wb.
    assign wr_en   = reset_n && (count != '0) && !port_busy;
    assign wr_dest = reset_n ? ADDR_W'(view[0].dest) : '0;
    assign wr_data = reset_n ? DATA_W'(view[0].data) : '0;
    assign pending = count;
    assign idle    = (count == '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .pop        (wr_en),
        .push_entry (push_entry),
        .count      (count),
        .view       (view),
        .view_valid (view_valid)
    );

`ifdef WB_FWD_EN
    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (reset_n && view_valid[k] && (lk_addr != ADDR_W'(REG_ZERO)) &&
                (view[k].dest == REG_ADDR_W'(lk_addr))) begin
                lk_hit  = 1'b1;
                lk_data = DATA_W'(view[k].data);
            end
        end
    end
`else
    logic unused_lk;
    assign unused_lk = ^lk_addr;
    assign lk_hit    = 1'b0;
    assign lk_data   = '0;
`endif

endmodule
